// File: rtl/pipe_id_ctrl_pkg.sv
// Shared MIPS decode definitions for the ID stage: opcode/funct constants,
// fetch-mux select encodings and a small decode helper.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    PC_SEL_NPC = 2'd0,
    PC_SEL_BR  = 2'd1,
    PC_SEL_J   = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic beq;
    logic bne;
    logic jmp;
    logic jr;
    logic uses_rt;
  } id_dec_t;

  function automatic id_dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    id_dec_t d;
    d.beq     = (op == OP_BEQ);
    d.bne     = (op == OP_BNE);
    d.jr      = (op == OP_RTYPE) && (funct == FN_JR);
    d.jmp     = (op == OP_J) || (op == OP_JAL) || d.jr;
    d.uses_rt = (op == OP_RTYPE) || (op == OP_SW) || d.beq || d.bne;
    return d;
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational hazard detection for the ID stage: load-use against EX and
// branch/jr operand hazards against EX writers and MEM loads.
module id_hazard_unit (
  input  logic       id_valid,
  input  logic       uses_rt,
  input  logic       cmp_rs,
  input  logic       cmp_rt,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       ex_wreg,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_mem_read,
  output logic       stall
);

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, operand_hz;

  // Register 0 is hardwired, so it never creates a dependency.
  assign rs_ex  = (rs_addr != 5'd0) && (ex_rd == rs_addr);
  assign rt_ex  = (rt_addr != 5'd0) && (ex_rd == rt_addr);
  assign rs_mem = (rs_addr != 5'd0) && (mem_rd == rs_addr);
  assign rt_mem = (rt_addr != 5'd0) && (mem_rd == rt_addr);

  assign load_use   = ex_mem_read && (rs_ex || (uses_rt && rt_ex));
  assign operand_hz = (cmp_rs && ((ex_wreg && rs_ex) || (mem_mem_read && rs_mem)))
                   || (cmp_rt && ((ex_wreg && rt_ex) || (mem_mem_read && rt_mem)));

  assign stall = id_valid && (load_use || operand_hz);

endmodule

// File: rtl/pipe_id_ctrl.sv
// ID stage control: IF/ID register, branch/jump resolution, fetch redirect,
// wrong-path squash and a saturating bubble counter.
module pipe_id_ctrl
  import mips_defs::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_npc,
  input  logic [31:0]      in_instruction,
  output logic             out_stall,
  output logic [1:0]       out_pc_sel,
  output logic [31:0]      out_pc_baddr,
  output logic [31:0]      out_pc_jaddr,
  output logic [4:0]       out_rs_addr,
  output logic [4:0]       out_rt_addr,
  input  logic [31:0]      in_rs_data,
  input  logic [31:0]      in_rt_data,
  input  logic             in_ex_wreg,
  input  logic [4:0]       in_ex_rd,
  input  logic             in_ex_mem_read,
  input  logic             in_mem_wreg,
  input  logic [4:0]       in_mem_rd,
  input  logic             in_mem_mem_read,
  input  logic [31:0]      in_mem_result,
  output logic [31:0]      out_id_pc,
  output logic [31:0]      out_id_npc,
  output logic [31:0]      out_id_instr,
  output logic             out_id_valid,
  output logic [CNT_W-1:0] out_bubble_cnt
);

  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_npc_q, id_npc_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  id_dec_t     dec;
  logic [4:0]  rs, rt;
  logic [31:0] rs_fwd, rt_fwd, br_off;
  logic        stall, redirect;
  pc_sel_e     pc_sel;

  assign rs  = id_instr_q[25:21];
  assign rt  = id_instr_q[20:16];
  assign dec = decode(id_instr_q[31:26], id_instr_q[5:0]);

  // A MEM load result is not ready yet; only ALU results are forwarded.
  always_comb begin
    rs_fwd = in_rs_data;
    rt_fwd = in_rt_data;
    if (in_mem_wreg && !in_mem_mem_read && (rs != 5'd0) && (in_mem_rd == rs))
      rs_fwd = in_mem_result;
    if (in_mem_wreg && !in_mem_mem_read && (rt != 5'd0) && (in_mem_rd == rt))
      rt_fwd = in_mem_result;
  end

  id_hazard_unit u_hazard (
    .id_valid     (id_valid_q),
    .uses_rt      (dec.uses_rt),
    .cmp_rs       (dec.beq | dec.bne | dec.jr),
    .cmp_rt       (dec.beq | dec.bne),
    .rs_addr      (rs),
    .rt_addr      (rt),
    .ex_wreg      (in_ex_wreg),
    .ex_rd        (in_ex_rd),
    .ex_mem_read  (in_ex_mem_read),
    .mem_rd       (in_mem_rd),
    .mem_mem_read (in_mem_mem_read),
    .stall        (stall)
  );

  // A stalled branch must not redirect; it resolves once operands are safe.
  always_comb begin
    pc_sel = PC_SEL_NPC;
    if (id_valid_q && !stall) begin
      if ((dec.beq && (rs_fwd == rt_fwd)) || (dec.bne && (rs_fwd != rt_fwd)))
        pc_sel = PC_SEL_BR;
      else if (dec.jmp)
        pc_sel = PC_SEL_J;
    end
  end

  assign redirect = (pc_sel != PC_SEL_NPC);
  assign br_off   = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};

  assign out_stall      = stall;
  assign out_pc_sel     = pc_sel;
  assign out_pc_baddr   = id_npc_q + br_off;
  assign out_pc_jaddr   = dec.jr ? rs_fwd : {id_npc_q[31:28], id_instr_q[25:0], 2'b00};
  assign out_rs_addr    = rs;
  assign out_rt_addr    = rt;
  assign out_id_pc      = id_pc_q;
  assign out_id_npc     = id_npc_q;
  assign out_id_instr   = id_instr_q;
  assign out_id_valid   = id_valid_q;
  assign out_bubble_cnt = bubble_cnt_q;

  always_comb begin
    id_pc_d      = id_pc_q;
    id_npc_d     = id_npc_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!stall) begin
      if (redirect) begin
        id_instr_d = 32'h0;
        id_valid_d = 1'b0;
      end else begin
        id_pc_d    = in_pc;
        id_npc_d   = in_npc;
        id_instr_d = in_instruction;
        id_valid_d = 1'b1;
      end
    end
    if ((stall || redirect) && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      id_pc_q      <= RESET_PC;
      id_npc_q     <= RESET_PC + 32'd4;
      id_instr_q   <= 32'h0;
      id_valid_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      id_pc_q      <= id_pc_d;
      id_npc_q     <= id_npc_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_id_ctrl.sv
// Self-checking bench for pipe_id_ctrl: behavioural ID-stage model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_pipe_id_ctrl;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [31:0] in_pc, in_npc, in_instruction;
  logic [31:0] in_rs_data, in_rt_data, in_mem_result;
  logic        in_ex_wreg, in_ex_mem_read, in_mem_wreg, in_mem_mem_read;
  logic [4:0]  in_ex_rd, in_mem_rd;

  logic        out_stall, out_id_valid;
  logic [1:0]  out_pc_sel;
  logic [31:0] out_pc_baddr, out_pc_jaddr, out_id_pc, out_id_npc, out_id_instr;
  logic [4:0]  out_rs_addr, out_rt_addr;
  logic [15:0] out_bubble_cnt;

  logic        s_stall, s_id_valid;
  logic [1:0]  s_pc_sel;
  logic [31:0] s_pc_baddr, s_pc_jaddr, s_id_pc, s_id_npc, s_id_instr;
  logic [4:0]  s_rs_addr, s_rt_addr;
  logic [3:0]  s_bubble_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_en = 1'b0;

  always #5 in_clk = ~in_clk;

  pipe_id_ctrl dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_pc(in_pc), .in_npc(in_npc),
    .in_instruction(in_instruction), .out_stall(out_stall), .out_pc_sel(out_pc_sel),
    .out_pc_baddr(out_pc_baddr), .out_pc_jaddr(out_pc_jaddr),
    .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_ex_wreg(in_ex_wreg), .in_ex_rd(in_ex_rd), .in_ex_mem_read(in_ex_mem_read),
    .in_mem_wreg(in_mem_wreg), .in_mem_rd(in_mem_rd), .in_mem_mem_read(in_mem_mem_read),
    .in_mem_result(in_mem_result), .out_id_pc(out_id_pc), .out_id_npc(out_id_npc),
    .out_id_instr(out_id_instr), .out_id_valid(out_id_valid), .out_bubble_cnt(out_bubble_cnt)
  );

  pipe_id_ctrl #(.CNT_W(4)) dut_sat (
    .in_clk(in_clk), .in_rst(in_rst), .in_pc(in_pc), .in_npc(in_npc),
    .in_instruction(in_instruction), .out_stall(s_stall), .out_pc_sel(s_pc_sel),
    .out_pc_baddr(s_pc_baddr), .out_pc_jaddr(s_pc_jaddr),
    .out_rs_addr(s_rs_addr), .out_rt_addr(s_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_ex_wreg(in_ex_wreg), .in_ex_rd(in_ex_rd), .in_ex_mem_read(in_ex_mem_read),
    .in_mem_wreg(in_mem_wreg), .in_mem_rd(in_mem_rd), .in_mem_mem_read(in_mem_mem_read),
    .in_mem_result(in_mem_result), .out_id_pc(s_id_pc), .out_id_npc(s_id_npc),
    .out_id_instr(s_id_instr), .out_id_valid(s_id_valid), .out_bubble_cnt(s_bubble_cnt)
  );

  // Model state: ID register contents plus an unbounded bubble count.
  logic [31:0] m_pc, m_npc, m_instr;
  logic        m_valid;
  int          m_cnt;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] baddr;
    logic [31:0] jaddr;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r != 5'd0 && in_mem_wreg && !in_mem_mem_read && in_mem_rd == r) return in_mem_result;
    return rf;
  endfunction

  function automatic exp_t model_eval();
    exp_t        e;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [31:0] a, b;
    bit          is_br, is_jr, is_jmp, reads_rt, ex_rs, ex_rt, mem_rs, mem_rt, lu, bh;
    int          off;
    op = m_instr[31:26]; fn = m_instr[5:0];
    rs = m_instr[25:21]; rt = m_instr[20:16];
    is_br    = (op == 6'h04) || (op == 6'h05);
    is_jr    = (op == 6'h00) && (fn == 6'h08);
    is_jmp   = (op == 6'h02) || (op == 6'h03) || is_jr;
    reads_rt = (op == 6'h00) || (op == 6'h2B) || is_br;
    ex_rs  = (rs != 0) && (in_ex_rd == rs);
    ex_rt  = (rt != 0) && (in_ex_rd == rt);
    mem_rs = (rs != 0) && (in_mem_rd == rs);
    mem_rt = (rt != 0) && (in_mem_rd == rt);
    lu = in_ex_mem_read && (ex_rs || (reads_rt && ex_rt));
    bh = ((is_br || is_jr) && ((in_ex_wreg && ex_rs) || (in_mem_mem_read && mem_rs)))
      || (is_br && ((in_ex_wreg && ex_rt) || (in_mem_mem_read && mem_rt)));
    e.stall = m_valid && (lu || bh);
    a = operand(rs, in_rs_data);
    b = operand(rt, in_rt_data);
    e.sel = 2'd0;
    if (m_valid && !e.stall) begin
      if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) e.sel = 2'd1;
      else if (is_jmp) e.sel = 2'd2;
    end
    off = int'($signed(m_instr[15:0]));
    e.baddr = m_npc + 32'(off * 4);
    e.jaddr = is_jr ? a : ((m_npc & 32'hF000_0000) + 32'(m_instr[25:0]) * 32'd4);
    return e;
  endfunction

  always @(posedge in_clk) begin
    exp_t e;
    e = model_eval();
    if (!in_rst) begin
      m_pc = 32'h0; m_npc = 32'h4; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 0;
    end else begin
      if (e.stall || e.sel != 2'd0) m_cnt++;
      if (!e.stall) begin
        if (e.sel != 2'd0) begin
          m_instr = 32'h0; m_valid = 1'b0;
        end else begin
          m_pc = in_pc; m_npc = in_npc; m_instr = in_instruction; m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge in_clk) begin
    exp_t e;
    if (chk_en) begin
      e = model_eval();
      check("stall", 32'(out_stall), 32'(e.stall));
      check("pc_sel", 32'(out_pc_sel), 32'(e.sel));
      check("id_instr", out_id_instr, m_instr);
      check("id_valid", 32'(out_id_valid), 32'(m_valid));
      check("rs_addr", 32'(out_rs_addr), 32'(m_instr[25:21]));
      check("rt_addr", 32'(out_rt_addr), 32'(m_instr[20:16]));
      check("bubble16", 32'(out_bubble_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("bubble4", 32'(s_bubble_cnt), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
      check("sat_stall", 32'(s_stall), 32'(e.stall));
      check("sat_pc_sel", 32'(s_pc_sel), 32'(e.sel));
      check("sat_id_instr", s_id_instr, m_instr);
      check("sat_id_valid", 32'(s_id_valid), 32'(m_valid));
      check("sat_rs_rt", {22'd0, s_rs_addr, s_rt_addr}, {22'd0, m_instr[25:16]});
      if (m_valid) begin
        check("id_pc", out_id_pc, m_pc);
        check("id_npc", out_id_npc, m_npc);
        check("baddr", out_pc_baddr, e.baddr);
        check("jaddr", out_pc_jaddr, e.jaddr);
        check("sat_id_pc", s_id_pc, m_pc);
        check("sat_id_npc", s_id_npc, m_npc);
        check("sat_baddr", s_pc_baddr, e.baddr);
        check("sat_jaddr", s_pc_jaddr, e.jaddr);
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
    in_pc = pc; in_npc = pc + 32'd4; in_instruction = instr;
  endtask

  task automatic clear_tags();
    in_ex_wreg = 0; in_ex_rd = 0; in_ex_mem_read = 0;
    in_mem_wreg = 0; in_mem_rd = 0; in_mem_mem_read = 0; in_mem_result = 0;
  endtask

  // Table of ID instruction vs. EX load destination and the stall it must cause.
  logic [31:0] tbl_instr [4] = '{32'h0000_1020, 32'h2029_0005, 32'hAC29_0000, 32'h2029_0005};
  logic [4:0]  tbl_ex_rd [4] = '{5'd0, 5'd9, 5'd9, 5'd1};
  logic        tbl_stall [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    in_rst = 1'b0;
    set_if(32'h0, 32'h0);
    in_rs_data = 0; in_rt_data = 0;
    clear_tags();

    // Reset
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_instr", out_id_instr, 32'h0);
    check("rst_valid", 32'(out_id_valid), 32'd0);
    check("rst_stall", 32'(out_stall), 32'd0);
    check("rst_pc_sel", 32'(out_pc_sel), 32'd0);
    check("rst_cnt", 32'(out_bubble_cnt), 32'd0);
    check("rst_pc", out_id_pc, 32'h0);
    check("rst_npc", out_id_npc, 32'h4);

    // Taken beq backwards: target 0x104 - 8
    in_rst = 1'b1;
    set_if(32'h100, 32'h10A5_FFFE);
    in_rs_data = 32'h55; in_rt_data = 32'h55;
    tick();
    set_if(32'h104, 32'h0109_4020);
    #1;
    check("beq_sel", 32'(out_pc_sel), 32'd1);
    check("beq_baddr", out_pc_baddr, 32'h0FC);
    check("beq_stall", 32'(out_stall), 32'd0);
    tick();
    set_if(32'h0FC, 32'h0109_5020);
    #1;
    check("beq_flush_instr", out_id_instr, 32'h0);
    check("beq_flush_valid", 32'(out_id_valid), 32'd0);
    check("beq_cnt", 32'(out_bubble_cnt), 32'd1);

    // Load-use on rs
    tick();
    set_if(32'h100, 32'h0109_4020);
    in_ex_mem_read = 1; in_ex_wreg = 1; in_ex_rd = 5'd8;
    #1;
    check("lu_stall", 32'(out_stall), 32'd1);
    check("lu_sel", 32'(out_pc_sel), 32'd0);
    tick();
    check("lu_hold_instr", out_id_instr, 32'h0109_5020);
    check("lu_hold_pc", out_id_pc, 32'h0FC);
    check("lu_cnt", 32'(out_bubble_cnt), 32'd2);
    clear_tags();
    #1;
    check("lu_release", 32'(out_stall), 32'd0);

    // Register 0 and uses_rt boundaries
    for (int i = 0; i < 4; i++) begin
      clear_tags();
      set_if(32'h180 + 32'(i * 4), tbl_instr[i]);
      tick();
      in_ex_mem_read = 1; in_ex_rd = tbl_ex_rd[i];
      #1;
      check("lu_table", 32'(out_stall), 32'(tbl_stall[i]));
    end
    clear_tags();

    // bne with rs forwarded from MEM
    set_if(32'h200, 32'h1460_0004);
    in_rs_data = 0; in_rt_data = 0;
    tick();
    in_mem_rd = 5'd3; in_mem_result = 32'd7;
    #1;
    check("bne_nofwd_sel", 32'(out_pc_sel), 32'd0);
    in_mem_wreg = 1;
    #1;
    check("bne_fwd_sel", 32'(out_pc_sel), 32'd1);
    check("bne_baddr", out_pc_baddr, 32'h214);
    in_mem_mem_read = 1;
    #1;
    check("bne_memload_stall", 32'(out_stall), 32'd1);
    check("bne_memload_sel", 32'(out_pc_sel), 32'd0);
    in_mem_mem_read = 0;
    set_if(32'h204, 32'h0109_4020);
    tick();
    clear_tags();
    check("bne_cnt", 32'(out_bubble_cnt), 32'd3);

    // jr $31, then with an EX writer of $31
    set_if(32'h300, 32'h03E0_0008);
    tick();
    in_rs_data = 32'h400;
    #1;
    check("jr_sel", 32'(out_pc_sel), 32'd2);
    check("jr_jaddr", out_pc_jaddr, 32'h400);
    in_ex_wreg = 1; in_ex_rd = 5'd31;
    #1;
    check("jr_hz_stall", 32'(out_stall), 32'd1);
    check("jr_hz_sel", 32'(out_pc_sel), 32'd0);
    tick();
    check("jr_hold", out_id_instr, 32'h03E0_0008);
    clear_tags();
    #1;
    check("jr_resolve", 32'(out_pc_sel), 32'd2);
    set_if(32'h304, 32'h0109_4020);
    tick();

    // j across a 256MB region boundary uses the upper bits of npc
    set_if(32'h3FFF_FFFC, 32'h0800_0100);
    tick();
    #1;
    check("j_sel", 32'(out_pc_sel), 32'd2);
    check("j_jaddr", out_pc_jaddr, 32'h4000_0400);
    set_if(32'h4000_0000, 32'h0109_4020);
    tick();
    check("j_cnt", 32'(out_bubble_cnt), 32'd6);

    // Long stall saturates the 4-bit counter
    set_if(32'h500, 32'h0109_5020);
    tick();
    in_ex_mem_read = 1; in_ex_rd = 5'd9;
    repeat (20) tick();
    check("sat_cnt4", 32'(s_bubble_cnt), 32'd15);
    check("sat_cnt16", 32'(out_bubble_cnt), 32'd26);
    check("sat_still_stall", 32'(out_stall), 32'd1);

    // Reset during a stall
    in_rst = 1'b0;
    tick();
    check("rst_mid_stall", 32'(out_stall), 32'd0);
    check("rst_mid_valid", 32'(out_id_valid), 32'd0);
    check("rst_mid_cnt", 32'(out_bubble_cnt), 32'd0);
    check("rst_mid_cnt4", 32'(s_bubble_cnt), 32'd0);
    in_rst = 1'b1;
    clear_tags();
    tick();
    tick();
    @(negedge in_clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
